// File: rtl/fbank_pkg.sv
// Shared types and constants for the function-bank code decoder.
// GOLDEN_CODE[m] is the 10-bit response of a healthy bank to minterm m = {w,x,y,z}.
package fbank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_FUNC = 10;
    localparam int N_IN   = 4;
    localparam int N_MIN  = 1 << N_IN;

    localparam logic [N_FUNC-1:0] GOLDEN_CODE [N_MIN] = '{
        10'h194, 10'h049, 10'h318, 10'h1BE,
        10'h1EE, 10'h335, 10'h133, 10'h3B6,
        10'h0E9, 10'h38D, 10'h205, 10'h0CF,
        10'h376, 10'h35B, 10'h0E3, 10'h266
    };

endpackage

// File: rtl/fbank_scan_ctr.sv
// Settle down-counter plus minterm index counter for the decoder scan.
// sample_stb marks the cycle f_in is compared; last_stb marks the sample of index 15.
module fbank_scan_ctr
    import fbank_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            run,
    output logic [N_IN-1:0] idx,
    output logic            sample_stb,
    output logic            last_stb
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    logic [3:0]      settle_q, settle_d;
    logic [N_IN-1:0] idx_q, idx_d;

    always_comb begin
        sample_stb = run && (settle_q == 4'd0);
        last_stb   = sample_stb && (idx_q == {N_IN{1'b1}});
        settle_d   = settle_q;
        idx_d      = idx_q;
        if (start) begin
            settle_d = SETTLE_L;
            idx_d    = '0;
        end else if (run) begin
            if (sample_stb) begin
                settle_d = SETTLE_L;
                // Hold at 15 on the final sample; the parent leaves SCAN there.
                if (!last_stb) begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                settle_d = settle_q - 4'd1;
            end
        end else begin
            settle_d = 4'd0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= 4'd0;
            idx_q    <= '0;
        end else begin
            settle_q <= settle_d;
            idx_q    <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/fbank_code_decoder.sv
// Inverts the function bank by driving every minterm and comparing the bank response.
// state | meaning: IDLE = ready for request; SCAN = probing minterms; DONE = response held
module fbank_code_decoder
    import fbank_pkg::*;
#(
    parameter int SETTLE     = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_FUNC-1:0] code_in,
    output logic              probe_valid,
    output logic              probe_w,
    output logic              probe_x,
    output logic              probe_y,
    output logic              probe_z,
    input  logic [N_FUNC-1:0] f_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [N_IN-1:0]   resp_idx,
    output logic [4:0]        resp_count
);

    state_t            state_q, state_d;
    logic [N_FUNC-1:0] code_q, code_d;
    logic              hit_q, hit_d;
    logic [N_IN-1:0]   ridx_q, ridx_d;
    logic [4:0]        count_q, count_d;

    logic              start;
    logic              run;
    logic              match;
    logic [N_IN-1:0]   scan_idx;
    logic              sample_stb;
    logic              last_stb;

    assign run = (state_q == SCAN);

    fbank_scan_ctr #(.SETTLE(SETTLE)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .run        (run),
        .idx        (scan_idx),
        .sample_stb (sample_stb),
        .last_stb   (last_stb)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hit_d   = hit_q;
        ridx_d  = ridx_q;
        count_d = count_q;
        start   = 1'b0;
        match   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    code_d  = code_in;
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    count_d = 5'd0;
                    start   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (sample_stb) begin
                    match = (f_in == code_q);
                    if (match) begin
                        count_d = count_q + 5'd1;
                        if (!hit_q) begin
                            hit_d  = 1'b1;
                            ridx_d = scan_idx;
                        end
                    end
                    if (last_stb || (match && (EARLY_EXIT != 0))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            hit_q   <= 1'b0;
            ridx_q  <= '0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hit_q   <= hit_d;
            ridx_q  <= ridx_d;
            count_q <= count_d;
        end
    end

    // Probe bus is gated so it reads zero outside SCAN, including the first DONE cycle.
    assign req_ready   = (state_q == IDLE);
    assign probe_valid = run;
    assign probe_w     = run & scan_idx[3];
    assign probe_x     = run & scan_idx[2];
    assign probe_y     = run & scan_idx[1];
    assign probe_z     = run & scan_idx[0];
    assign resp_valid  = (state_q == DONE);
    assign resp_hit    = hit_q;
    assign resp_idx    = ridx_q;
    assign resp_count  = count_q;

endmodule

// File: tb/tb_fbank_code_decoder.sv
// Scoreboard bench: three decoders (SETTLE/EARLY_EXIT variants) each fronting a bank model.
// Latency is counted as the number of rising edges from the accept edge to the first edge that sees resp_valid high.
module tb_fbank_code_decoder;
    import fbank_pkg::*;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        logic [4:0] cnt;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_u      [3];
    logic       req_valid  [3];
    logic [9:0] code_in    [3];
    logic       resp_ready [3];
    logic       fault      [3];
    logic       req_ready  [3];
    logic       probe_valid[3];
    logic       pw [3], px [3], py [3], pz [3];
    logic [9:0] f_in       [3];
    logic       resp_valid [3];
    logic       resp_hit   [3];
    logic [3:0] resp_idx   [3];
    logic [4:0] resp_count [3];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   acc [3];
    logic active [3];
    exp_t cur [3];
    exp_t q0[$], q1[$], q2[$];

    function automatic logic [9:0] bank_out(input logic [3:0] m, input logic flt);
        logic [9:0] r;
        r = GOLDEN_CODE[m];
        if (flt && (m == 4'd3 || m == 4'd14)) r = 10'h0E3;
        return r;
    endfunction

    assign f_in[0] = bank_out({pw[0], px[0], py[0], pz[0]}, fault[0]);
    assign f_in[1] = bank_out({pw[1], px[1], py[1], pz[1]}, fault[1]);
    assign f_in[2] = bank_out({pw[2], px[2], py[2], pz[2]}, fault[2]);

    fbank_code_decoder #(.SETTLE(1), .EARLY_EXIT(0)) dut_a (
        .clk(clk), .rst(rst_u[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .code_in(code_in[0]), .probe_valid(probe_valid[0]),
        .probe_w(pw[0]), .probe_x(px[0]), .probe_y(py[0]), .probe_z(pz[0]),
        .f_in(f_in[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_hit(resp_hit[0]), .resp_idx(resp_idx[0]), .resp_count(resp_count[0]));

    fbank_code_decoder #(.SETTLE(0), .EARLY_EXIT(0)) dut_b (
        .clk(clk), .rst(rst_u[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .code_in(code_in[1]), .probe_valid(probe_valid[1]),
        .probe_w(pw[1]), .probe_x(px[1]), .probe_y(py[1]), .probe_z(pz[1]),
        .f_in(f_in[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_hit(resp_hit[1]), .resp_idx(resp_idx[1]), .resp_count(resp_count[1]));

    fbank_code_decoder #(.SETTLE(1), .EARLY_EXIT(1)) dut_c (
        .clk(clk), .rst(rst_u[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .code_in(code_in[2]), .probe_valid(probe_valid[2]),
        .probe_w(pw[2]), .probe_x(px[2]), .probe_y(py[2]), .probe_z(pz[2]),
        .f_in(f_in[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_hit(resp_hit[2]), .resp_idx(resp_idx[2]), .resp_count(resp_count[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int u, input logic h, input logic [3:0] i, input logic [4:0] c, input int l);
        exp_t e;
        e.hit = h; e.idx = i; e.cnt = c; e.lat = l;
        case (u)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int u);
        case (u)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpop(input int u, output exp_t e);
        case (u)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Monitor: compare on the first DONE cycle, then check the response holds steady.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (resp_valid[u]) begin
                if (!active[u]) begin
                    active[u] = 1'b1;
                    if (qsize(u) == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_resp unit %0d: got response, expected none", u);
                    end else begin
                        qpop(u, cur[u]);
                        chk($sformatf("u%0d_hit", u), resp_hit[u], cur[u].hit);
                        chk($sformatf("u%0d_idx", u), resp_idx[u], cur[u].idx);
                        chk($sformatf("u%0d_count", u), resp_count[u], cur[u].cnt);
                        chk($sformatf("u%0d_latency", u), cyc - acc[u] + 1, cur[u].lat);
                    end
                end else begin
                    chk($sformatf("u%0d_hold_hit", u), resp_hit[u], cur[u].hit);
                    chk($sformatf("u%0d_hold_idx", u), resp_idx[u], cur[u].idx);
                    chk($sformatf("u%0d_hold_count", u), resp_count[u], cur[u].cnt);
                end
            end else begin
                active[u] = 1'b0;
            end
        end
    end

    task automatic issue(input int u, input logic [9:0] code);
        int n = 0;
        @(negedge clk);
        while (!req_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) begin
            chk($sformatf("u%0d_req_ready_timeout", u), 0, 1);
            return;
        end
        code_in[u]   = code;
        req_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        acc[u]       = cyc;
        req_valid[u] = 1'b0;
        code_in[u]   = ~code;
    endtask

    task automatic wait_valid(input int u);
        int n = 0;
        while (!resp_valid[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid[u]) chk($sformatf("u%0d_resp_timeout", u), 0, 1);
    endtask

    task automatic finish_resp(input int u);
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("u%0d_drop_after_hs", u), resp_valid[u], 0);
        chk($sformatf("u%0d_ready_after_hs", u), req_ready[u], 1);
    endtask

    task automatic run_one(input int u, input logic [9:0] code, input logic h,
                           input logic [3:0] i, input logic [4:0] c, input int l);
        push(u, h, i, c, l);
        issue(u, code);
        wait_valid(u);
        finish_resp(u);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst_u[u] = 1'b1; req_valid[u] = 1'b0; code_in[u] = '0;
            resp_ready[u] = 1'b1; fault[u] = 1'b0; active[u] = 1'b0; acc[u] = 0;
        end
        #23;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_rst_req_ready", u), req_ready[u], 1);
            chk($sformatf("u%0d_rst_probe_valid", u), probe_valid[u], 0);
            chk($sformatf("u%0d_rst_probe", u), {pw[u], px[u], py[u], pz[u]}, 0);
            chk($sformatf("u%0d_rst_resp_valid", u), resp_valid[u], 0);
            chk($sformatf("u%0d_rst_resp", u), {resp_hit[u], resp_idx[u], resp_count[u]}, 0);
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) rst_u[u] = 1'b0;

        // Full scan with settle cycles.
        run_one(0, 10'h194, 1'b1, 4'd0, 5'd1, 33);

        // Every golden codeword maps back to its own minterm.
        for (int i = 0; i < 16; i++) begin
            run_one(1, GOLDEN_CODE[i], 1'b1, 4'(i), 5'd1, 17);
        end

        // Early exit at both ends and a miss that must scan everything.
        run_one(2, 10'h194, 1'b1, 4'd0, 5'd1, 3);
        run_one(2, 10'h266, 1'b1, 4'd15, 5'd1, 33);
        run_one(2, 10'h000, 1'b0, 4'd0, 5'd0, 33);

        // Faulty bank: duplicate codeword, then backpressure on the response.
        fault[0]      = 1'b1;
        resp_ready[0] = 1'b0;
        push(0, 1'b1, 4'd3, 5'd2, 33);
        issue(0, 10'h0E3);
        wait_valid(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("u0_stall_req_ready", req_ready[0], 0);
            chk("u0_stall_resp_valid", resp_valid[0], 1);
            code_in[0]   = 10'h194;
            req_valid[0] = (k == 2);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        finish_resp(0);
        @(negedge clk);
        chk("u0_no_stale_accept", probe_valid[0], 0);
        fault[0] = 1'b0;

        // Asynchronous reset in the middle of a scan.
        issue(0, 10'h3B6);
        begin
            int n = 0;
            while (!(probe_valid[0] && {pw[0], px[0], py[0], pz[0]} == 4'd7) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("u0_reached_idx7", {pw[0], px[0], py[0], pz[0]}, 7);
        end
        #1;
        rst_u[0] = 1'b1;
        #1;
        chk("u0_arst_probe_valid", probe_valid[0], 0);
        chk("u0_arst_probe", {pw[0], px[0], py[0], pz[0]}, 0);
        chk("u0_arst_req_ready", req_ready[0], 1);
        chk("u0_arst_resp_valid", resp_valid[0], 0);
        repeat (2) @(negedge clk);
        rst_u[0] = 1'b0;
        push(0, 1'b1, 4'd0, 5'd1, 33);
        issue(0, 10'h194);
        @(negedge clk);
        chk("u0_rescan_probe_valid", probe_valid[0], 1);
        chk("u0_rescan_start_idx", {pw[0], px[0], py[0], pz[0]}, 0);
        wait_valid(0);
        finish_resp(0);

        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk($sformatf("u%0d_scoreboard_empty", u), qsize(u), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
